// File: rtl/bram_bank_array_if.sv
// Bus bundle for bram_bank_array: one write port and one read port that
// share a single word address space, plus the read result and its strobe.
//
//   cs        chip select, gates both we and re
//   we        write enable
//   waddr     write word address
//   wmask     per-channel write enable
//   din       write data, CH_NUM channels packed LSB first
//   re        read enable
//   raddr     read word address
//   dout      read data, holds its value between reads
//   dout_vld  one-cycle strobe marking a fresh read result
//
// master: the side issuing reads/writes. slave: the memory.
interface bram_bank_array_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CH_NUM     = 3,
    parameter int DATA_WIDTH = 24
);
    logic                  cs;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [CH_NUM-1:0]     wmask;
    logic [DATA_WIDTH-1:0] din;
    logic                  re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_vld;

    modport master (
        output cs, we, waddr, wmask, din, re, raddr,
        input  dout, dout_vld
    );

    modport slave (
        input  cs, we, waddr, wmask, din, re, raddr,
        output dout, dout_vld
    );
endinterface

// File: rtl/bram_bank_array.sv
// bram_bank_array: BANK_NUM block-RAM banks of BANK_DEPTH words each, behind
// one write port and one read port sharing one address space. Used as the
// line/pixel buffer feeding the upsampling core with CH_NUM-channel pixels.
//
// Ports:
//   clk    clock, everything on the rising edge
//   rst_n  synchronous active-low reset; clears the read pipeline only,
//          memory contents are retained
//   bus    bram_bank_array_if.slave (cs/we/waddr/wmask/din/re/raddr in,
//          dout/dout_vld out)
//
// Address decode: word = addr[WA-1:0], bank = addr[WA +: BA]; all higher
// address bits are ignored so addresses wrap modulo BANK_DEPTH*BANK_NUM.
// Read latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
// RDW_MODE selects same-address read-during-write: 0 old data, 1 new data.
module bram_bank_array #(
    parameter int CH_WIDTH   = 8,
    parameter int CH_NUM     = 3,
    parameter int BANK_DEPTH = 32,
    parameter int BANK_NUM   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int OUT_REG    = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    bram_bank_array_if.slave  bus
);
    localparam int DATA_WIDTH = CH_WIDTH * CH_NUM;
    localparam int WA         = $clog2(BANK_DEPTH);
    // A single bank still gets a 1-bit (always zero) bank index so that no
    // zero-width vectors appear anywhere.
    localparam int BA         = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

    logic            wr_en;
    logic            rd_en;
    logic [WA-1:0]   wword;
    logic [WA-1:0]   rword;
    logic [BA-1:0]   wbank;
    logic [BA-1:0]   rbank;
    logic            same_addr;

    // Address bits above the decoded range are intentionally ignored.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{bus.waddr, bus.raddr};

    // Reset drops any access presented in the same cycle.
    assign wr_en = rst_n & bus.cs & bus.we;
    assign rd_en = rst_n & bus.cs & bus.re;

    assign wword = bus.waddr[WA-1:0];
    assign rword = bus.raddr[WA-1:0];

    generate
        if (BANK_NUM > 1) begin : g_bank_dec
            assign wbank = bus.waddr[WA +: BA];
            assign rbank = bus.raddr[WA +: BA];
        end else begin : g_single_bank
            assign wbank = '0;
            assign rbank = '0;
        end
    endgenerate

    assign same_addr = (wbank == rbank) && (wword == rword);

    // ------------------------------------------------------------------
    // Banks: plain arrays, one write port and one registered read port each,
    // so every bank maps onto a block RAM with byte-style write enables.
    // The read register is read-first; write-first is handled outside.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] bank_q [BANK_NUM];

    genvar gi;
    generate
        for (gi = 0; gi < BANK_NUM; gi++) begin : g_bank
            logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
            logic [DATA_WIDTH-1:0] q_reg;
            logic                  bank_we;
            logic                  bank_re;

            assign bank_we = wr_en && (wbank == BA'(gi));
            assign bank_re = rd_en && (rbank == BA'(gi));

            always_ff @(posedge clk) begin
                if (bank_we) begin
                    for (int ci = 0; ci < CH_NUM; ci++) begin
                        if (bus.wmask[ci]) begin
                            mem[wword][ci*CH_WIDTH +: CH_WIDTH] <= bus.din[ci*CH_WIDTH +: CH_WIDTH];
                        end
                    end
                end
            end

            // q_reg only loads on a read of this bank, so the selected
            // bank's q_reg naturally holds the last result between reads.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (bank_re) begin
                    q_reg <= mem[rword];
                end
            end

            assign bank_q[gi] = q_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: bank select plus write-first bypass. On a same-address
    // collision in write-first mode the written channels are captured
    // alongside the read and overlaid on the RAM output next cycle.
    // ------------------------------------------------------------------
    logic [BA-1:0]         rsel_reg;
    logic                  v1_reg;
    logic [CH_NUM-1:0]     byp_mask_reg;
    logic [DATA_WIDTH-1:0] byp_data_reg;
    logic [DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsel_reg     <= '0;
            v1_reg       <= 1'b0;
            byp_mask_reg <= '0;
            byp_data_reg <= '0;
        end else begin
            v1_reg <= rd_en;
            if (rd_en) begin
                rsel_reg     <= rbank;
                byp_data_reg <= bus.din;
                if ((RDW_MODE == 1) && wr_en && same_addr) begin
                    byp_mask_reg <= bus.wmask;
                end else begin
                    byp_mask_reg <= '0;
                end
            end
        end
    end

    always_comb begin
        s1_data = bank_q[rsel_reg];
        for (int ci = 0; ci < CH_NUM; ci++) begin
            if (byp_mask_reg[ci]) begin
                s1_data[ci*CH_WIDTH +: CH_WIDTH] = byp_data_reg[ci*CH_WIDTH +: CH_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional output register stage.
    // ------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] s2_reg;
            logic                  v2_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s2_reg <= '0;
                    v2_reg <= 1'b0;
                end else begin
                    v2_reg <= v1_reg;
                    if (v1_reg) begin
                        s2_reg <= s1_data;
                    end
                end
            end

            assign bus.dout     = s2_reg;
            assign bus.dout_vld = v2_reg;
        end else begin : g_out_direct
            assign bus.dout     = s1_data;
            assign bus.dout_vld = v1_reg;
        end
    endgenerate
endmodule

// File: tb/tb_bram_bank_array.sv
// Testbench for bram_bank_array. Two instances share one stimulus stream:
//   u_a: OUT_REG=1, RDW_MODE=0 (2-cycle latency, read-first)
//   u_b: OUT_REG=0, RDW_MODE=1 (1-cycle latency, write-first)
// A directed table (with hand-written expected read data) runs first, then
// a full memory fill and randomized cycles checked against a word-level
// model of the memory and a queue of pending read results.
module tb_bram_bank_array;
    logic clk;
    logic rst_n;

    bram_bank_array_if #(.ADDR_WIDTH(32), .CH_NUM(3), .DATA_WIDTH(24)) ifa ();
    bram_bank_array_if #(.ADDR_WIDTH(32), .CH_NUM(3), .DATA_WIDTH(24)) ifb ();

    bram_bank_array #(.OUT_REG(1), .RDW_MODE(0)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    bram_bank_array #(.OUT_REG(0), .RDW_MODE(1)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        cs;
        logic        we;
        logic [31:0] waddr;
        logic [2:0]  wmask;
        logic [23:0] din;
        logic        re;
        logic [31:0] raddr;
        logic [23:0] ea;   // expected read data, read-first instance
        logic [23:0] eb;   // expected read data, write-first instance
    } vec_t;

    typedef struct {
        logic [23:0] val;
        int          due;
    } pend_t;

    vec_t        tbl[$];
    pend_t       qa[$];
    pend_t       qb[$];
    logic [23:0] mem_m [128];
    logic [23:0] exp_a, exp_b;
    logic        expv_a, expv_b;
    int          cyc;
    int          n_vec;
    int          n_err;

    function automatic vec_t mk(logic r, logic c, logic w, logic [31:0] wa,
                                logic [2:0] m, logic [23:0] d, logic rd,
                                logic [31:0] ra, logic [23:0] ea, logic [23:0] eb);
        vec_t v;
        v.rst_n = r; v.cs = c; v.we = w; v.waddr = wa; v.wmask = m;
        v.din = d; v.re = rd; v.raddr = ra; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    function automatic logic [23:0] merge(logic [23:0] old, logic [23:0] d, logic [2:0] m);
        logic [23:0] r;
        r = old;
        for (int c = 0; c < 3; c++) begin
            if (m[c]) r[c*8 +: 8] = d[c*8 +: 8];
        end
        return r;
    endfunction

    // Delivers the head of a pending queue if it is due this cycle.
    task automatic deliver(inout pend_t q[$], output logic v, inout logic [23:0] d);
        v = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            v = 1'b1;
            d = q[0].val;
            void'(q.pop_front());
        end
    endtask

    // Drives one cycle of inputs and advances the model across the next edge.
    task automatic apply(input vec_t v, input bit use_tbl);
        logic [6:0]  wa, ra;
        logic [23:0] old, rd_a, rd_b;
        pend_t       p;
        rst_n     = v.rst_n;
        ifa.cs    = v.cs;    ifb.cs    = v.cs;
        ifa.we    = v.we;    ifb.we    = v.we;
        ifa.waddr = v.waddr; ifb.waddr = v.waddr;
        ifa.wmask = v.wmask; ifb.wmask = v.wmask;
        ifa.din   = v.din;   ifb.din   = v.din;
        ifa.re    = v.re;    ifb.re    = v.re;
        ifa.raddr = v.raddr; ifb.raddr = v.raddr;

        cyc++;
        wa = v.waddr[6:0];
        ra = v.raddr[6:0];
        if (!v.rst_n) begin
            qa.delete();
            qb.delete();
            exp_a = '0; exp_b = '0;
            expv_a = 1'b0; expv_b = 1'b0;
        end else begin
            old  = mem_m[ra];
            rd_a = old;
            rd_b = (v.cs && v.we && wa == ra) ? merge(old, v.din, v.wmask) : old;
            if (v.cs && v.re) begin
                p.val = use_tbl ? v.ea : rd_a; p.due = cyc + 1; qa.push_back(p);
                p.val = use_tbl ? v.eb : rd_b; p.due = cyc;     qb.push_back(p);
            end
            deliver(qa, expv_a, exp_a);
            deliver(qb, expv_b, exp_b);
            if (v.cs && v.we) mem_m[wa] = merge(mem_m[wa], v.din, v.wmask);
        end
    endtask

    task automatic check();
        n_vec++;
        if (ifa.dout_vld !== expv_a) begin
            n_err++;
            $display("FAIL a_vld cyc %0d: got %b want %b", cyc, ifa.dout_vld, expv_a);
        end
        n_vec++;
        if (ifa.dout !== exp_a) begin
            n_err++;
            $display("FAIL a_dout cyc %0d: got %h want %h", cyc, ifa.dout, exp_a);
        end
        n_vec++;
        if (ifb.dout_vld !== expv_b) begin
            n_err++;
            $display("FAIL b_vld cyc %0d: got %b want %b", cyc, ifb.dout_vld, expv_b);
        end
        n_vec++;
        if (ifb.dout !== exp_b) begin
            n_err++;
            $display("FAIL b_dout cyc %0d: got %h want %h", cyc, ifb.dout, exp_b);
        end
        if (expv_a) $display("cyc %0d read a=%h b_vld=%b b=%h", cyc, ifa.dout, ifb.dout_vld, ifb.dout);
    endtask

    initial begin
        vec_t        v;
        logic [31:0] tmp;
        bit          started;
        n_vec = 0; n_err = 0; cyc = 0; started = 1'b0;
        exp_a = '0; exp_b = '0; expv_a = 1'b0; expv_b = 1'b0;
        rst_n = 1'b0;
        ifa.cs = 0; ifa.we = 0; ifa.re = 0; ifa.waddr = 0; ifa.raddr = 0; ifa.wmask = 0; ifa.din = 0;
        ifb.cs = 0; ifb.we = 0; ifb.re = 0; ifb.waddr = 0; ifb.raddr = 0; ifb.wmask = 0; ifb.din = 0;

        // ---------------- directed table ----------------
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,5,7,24'hA1B2C3,0,0,0,0));
        tbl.push_back(mk(1,1,1,37,7,24'h112233,0,0,0,0));
        tbl.push_back(mk(1,1,1,133,7,24'h445566,0,0,0,0));
        tbl.push_back(mk(1,1,1,10,7,24'hFFFFFF,0,0,0,0));
        tbl.push_back(mk(1,1,1,7,7,24'hABCDEF,0,0,0,0));
        for (int k = 0; k < 7; k++) begin
            if (k != 5) tbl.push_back(mk(1,1,1,k,7,24'h100000 + 24'(k),0,0,0,0));
        end
        tbl.push_back(mk(1,1,0,0,0,0,1,5,24'h445566,24'h445566));
        tbl.push_back(mk(1,1,0,0,0,0,1,32'h1000_0025,24'h112233,24'h112233));
        tbl.push_back(mk(1,1,1,10,3'b010,24'h000000,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,10,24'hFF00FF,24'hFF00FF));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,1,7,7,24'h123456,1,7,24'hABCDEF,24'h123456));
        tbl.push_back(mk(1,1,0,0,0,0,1,7,24'h123456,24'h123456));
        tbl.push_back(mk(1,1,1,7,7,24'hABCDEF,0,0,0,0));
        tbl.push_back(mk(1,1,1,7,3'b001,24'h123456,1,7,24'hABCDEF,24'hABCD56));
        tbl.push_back(mk(1,1,0,0,0,0,1,7,24'hABCD56,24'hABCD56));
        tbl.push_back(mk(1,1,1,40,7,24'h777777,1,5,24'h445566,24'h445566));
        tbl.push_back(mk(1,1,0,0,0,0,1,40,24'h777777,24'h777777));
        tbl.push_back(mk(1,1,1,6,3'b000,24'h000000,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,6,24'h100006,24'h100006));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0));
        // burst of back-to-back reads, cs dropped at address 4
        for (int k = 0; k < 4; k++) tbl.push_back(mk(1,1,0,0,0,0,1,k,24'h100000 + 24'(k),24'h100000 + 24'(k)));
        tbl.push_back(mk(1,0,0,0,0,0,1,4,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,1,5,0,0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0));
        // reset one cycle after a read issue, with a write to addr 3
        tbl.push_back(mk(1,1,0,0,0,0,1,3,24'h100003,24'h100003));
        tbl.push_back(mk(0,1,1,3,7,24'hDEADBE,1,3,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,1,3,24'h100003,24'h100003));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            if (started) check();
            started = 1'b1;
            apply(tbl[i], 1'b1);
        end

        // ---------------- fill every word, random high address bits ----------------
        for (int k = 0; k < 128; k++) begin
            tmp = $urandom;
            v = mk(1,1,1,{tmp[31:7], 7'(k)},7,24'($urandom),0,0,0,0);
            @(negedge clk);
            check();
            apply(v, 1'b0);
        end

        // ---------------- randomized traffic vs model ----------------
        for (int i = 0; i < 600; i++) begin
            v.rst_n = ($urandom_range(0, 31) != 0);
            v.cs    = ($urandom_range(0, 7) != 0);
            v.we    = 1'($urandom);
            v.re    = 1'($urandom);
            v.waddr = $urandom;
            v.wmask = 3'($urandom);
            v.din   = 24'($urandom);
            tmp     = $urandom;
            v.raddr = ($urandom_range(0, 3) == 0) ? {tmp[31:7], v.waddr[6:0]} : tmp;
            v.ea    = '0;
            v.eb    = '0;
            @(negedge clk);
            check();
            apply(v, 1'b0);
        end

        // drain the pipeline
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check();
            apply(mk(1,0,0,0,0,0,0,0,0,0), 1'b0);
        end
        @(negedge clk);
        check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
